// File: rtl/replacement_policy_pipe_pkg.sv
// rtl/replacement_policy_pipe_pkg.sv - policy encodings, FSM states and replacement-state width helper
package replacement_policy_pipe_pkg;

  localparam int POLICY_LRU       = 0;
  localparam int POLICY_PLRU_MRU  = 1;
  localparam int POLICY_PLRU_TREE = 3;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } fsm_state_e;

  function automatic int state_width(input int policy, input int n_ways);
    case (policy)
      POLICY_LRU:      return n_ways * $clog2(n_ways);
      POLICY_PLRU_MRU: return n_ways;
      default:         return n_ways - 1;
    endcase
  endfunction

endpackage

// File: rtl/replacement_policy_pipe_logic.sv
// rtl/replacement_policy_pipe_logic.sv - combinational policy core: state update, victim choice, reset value
module replacement_policy_pipe_logic
  import replacement_policy_pipe_pkg::*;
#(
  parameter int N_WAYS     = 8,
  parameter int NWAY_W     = $clog2(N_WAYS),
  parameter int REP_POLICY = POLICY_PLRU_TREE,
  parameter int SW         = state_width(REP_POLICY, N_WAYS)
) (
  input  logic [SW-1:0]     upd_state_i,
  input  logic [N_WAYS-1:0] hit_i,
  input  logic [SW-1:0]     lkp_state_i,
  input  logic              bypass_i,
  input  logic [N_WAYS-1:0] valid_i,
  input  logic [N_WAYS-1:0] lock_i,
  output logic [SW-1:0]     next_state_o,
  output logic [SW-1:0]     reset_state_o,
  output logic [N_WAYS-1:0] victim_o,
  output logic [NWAY_W-1:0] victim_bin_o
);

  logic [N_WAYS-1:0] cand, free;
  logic [SW-1:0]     sel_state;
  logic [NWAY_W-1:0] first_cand, first_free, pol_way;

  // A fully locked set would leave nothing to pick, so locking is dropped then.
  assign cand      = (&lock_i) ? '1 : ~lock_i;
  assign free      = cand & ~valid_i;
  assign sel_state = bypass_i ? next_state_o : lkp_state_i;

  always_comb begin
    first_cand = '0;
    first_free = '0;
    for (int i = N_WAYS - 1; i >= 0; i--) begin
      if (cand[i]) first_cand = NWAY_W'(i);
      if (free[i]) first_free = NWAY_W'(i);
    end
  end

  assign victim_bin_o = (|free) ? first_free : pol_way;
  assign victim_o     = N_WAYS'(1) << victim_bin_o;

  if (REP_POLICY == POLICY_LRU) begin : g_lru
    logic [NWAY_W-1:0] hit_bin, hit_cnt, best_cnt;

    always_comb begin
      hit_bin = '0;
      for (int i = 0; i < N_WAYS; i++)
        if (hit_i[i]) hit_bin = NWAY_W'(i);
      hit_cnt       = upd_state_i[hit_bin*NWAY_W +: NWAY_W];
      next_state_o  = upd_state_i;
      reset_state_o = '0;
      for (int i = 0; i < N_WAYS; i++) begin
        reset_state_o[i*NWAY_W +: NWAY_W] = NWAY_W'(i);
        if (upd_state_i[i*NWAY_W +: NWAY_W] > hit_cnt)
          next_state_o[i*NWAY_W +: NWAY_W] = upd_state_i[i*NWAY_W +: NWAY_W] - 1'b1;
      end
      next_state_o[hit_bin*NWAY_W +: NWAY_W] = '1;
    end

    always_comb begin
      pol_way  = first_cand;
      best_cnt = sel_state[first_cand*NWAY_W +: NWAY_W];
      for (int i = 0; i < N_WAYS; i++)
        if (cand[i] && (sel_state[i*NWAY_W +: NWAY_W] < best_cnt)) begin
          best_cnt = sel_state[i*NWAY_W +: NWAY_W];
          pol_way  = NWAY_W'(i);
        end
    end
  end else if (REP_POLICY == POLICY_PLRU_MRU) begin : g_mru
    logic [N_WAYS-1:0] ored;

    always_comb begin
      reset_state_o = '0;
      ored          = upd_state_i | hit_i;
      next_state_o  = (&ored) ? hit_i : ored;
    end

    always_comb begin
      pol_way = first_cand;
      for (int i = N_WAYS - 1; i >= 0; i--)
        if (cand[i] && !sel_state[i]) pol_way = NWAY_W'(i);
    end
  end else begin : g_tree
    // Heap-numbered nodes 1..N_WAYS-1 live at bit (node-1); leaves are N_WAYS+way.
    int upd_node, lkp_node;

    always_comb begin
      reset_state_o = '0;
      next_state_o  = upd_state_i;
      upd_node      = N_WAYS;
      for (int i = 0; i < N_WAYS; i++)
        if (hit_i[i]) upd_node = N_WAYS + i;
      for (int l = 0; l < NWAY_W; l++) begin
        next_state_o[upd_node/2 - 1] = ~upd_node[0];
        upd_node = upd_node / 2;
      end
    end

    always_comb begin
      lkp_node = 1;
      for (int l = 0; l < NWAY_W; l++)
        lkp_node = 2 * lkp_node + int'(sel_state[lkp_node - 1]);
      pol_way = cand[lkp_node - N_WAYS] ? NWAY_W'(lkp_node - N_WAYS) : first_cand;
    end
  end

endmodule

// File: rtl/replacement_policy_pipe.sv
// rtl/replacement_policy_pipe.sv - victim selector with init/flush sequencer and registered lookup pipeline
module replacement_policy_pipe
  import replacement_policy_pipe_pkg::*;
#(
  parameter int N_WAYS        = 8,
  parameter int NWAY_W        = $clog2(N_WAYS),
  parameter int LINE_OFFSET_W = 7,
  parameter int REP_POLICY    = POLICY_PLRU_TREE
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     flush_i,
  output logic                     busy_o,
  input  logic                     req_valid_i,
  input  logic [LINE_OFFSET_W-1:0] req_addr_i,
  input  logic [N_WAYS-1:0]        req_way_valid_i,
  input  logic [N_WAYS-1:0]        req_lock_mask_i,
  output logic                     resp_valid_o,
  output logic [N_WAYS-1:0]        way_select_o,
  output logic [NWAY_W-1:0]        way_select_bin_o,
  input  logic                     upd_valid_i,
  input  logic [LINE_OFFSET_W-1:0] upd_addr_i,
  input  logic [N_WAYS-1:0]        upd_way_hit_i
);

  localparam int N_LINES = 2 ** LINE_OFFSET_W;
  localparam int SW      = state_width(REP_POLICY, N_WAYS);

  fsm_state_e               fsm_q, fsm_d;
  logic [LINE_OFFSET_W-1:0] init_cnt_q, init_cnt_d;
  logic [SW-1:0]            line_state_q [N_LINES];
  logic [SW-1:0]            next_state, reset_state;
  logic [N_WAYS-1:0]        victim;
  logic [NWAY_W-1:0]        victim_bin;
  logic                     resp_valid_q;
  logic [N_WAYS-1:0]        way_select_q;
  logic [NWAY_W-1:0]        way_select_bin_q;
  logic                     busy, req_fire, upd_fire, bypass;

  assign busy     = (fsm_q == ST_INIT);
  assign req_fire = req_valid_i & ~busy;
  assign upd_fire = upd_valid_i & ~busy & (|upd_way_hit_i);
  assign bypass   = upd_fire & (upd_addr_i == req_addr_i);

  always_comb begin
    fsm_d      = fsm_q;
    init_cnt_d = init_cnt_q;
    case (fsm_q)
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (&init_cnt_q) fsm_d = ST_READY;
      end
      default: begin
        if (flush_i) begin
          fsm_d      = ST_INIT;
          init_cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      fsm_q      <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      fsm_q      <= fsm_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Left out of reset on purpose: the INIT sweep rewrites every line.
  always_ff @(posedge clk_i) begin
    if (busy) line_state_q[init_cnt_q] <= reset_state;
    else if (upd_fire) line_state_q[upd_addr_i] <= next_state;
  end

  replacement_policy_pipe_logic #(
    .N_WAYS    (N_WAYS),
    .NWAY_W    (NWAY_W),
    .REP_POLICY(REP_POLICY),
    .SW        (SW)
  ) u_logic (
    .upd_state_i  (line_state_q[upd_addr_i]),
    .hit_i        (upd_way_hit_i),
    .lkp_state_i  (line_state_q[req_addr_i]),
    .bypass_i     (bypass),
    .valid_i      (req_way_valid_i),
    .lock_i       (req_lock_mask_i),
    .next_state_o (next_state),
    .reset_state_o(reset_state),
    .victim_o     (victim),
    .victim_bin_o (victim_bin)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      resp_valid_q     <= 1'b0;
      way_select_q     <= '0;
      way_select_bin_q <= '0;
    end else begin
      resp_valid_q <= req_fire;
      if (req_fire) begin
        way_select_q     <= victim;
        way_select_bin_q <= victim_bin;
      end
    end
  end

  assign busy_o           = busy;
  assign resp_valid_o     = resp_valid_q;
  assign way_select_o     = way_select_q;
  assign way_select_bin_o = way_select_bin_q;

  a_upd_onehot: assert property (@(posedge clk_i) disable iff (!reset_i)
    (upd_valid_i && !busy) |-> $onehot0(upd_way_hit_i));

endmodule

// File: doc/replacement_policy_pipe.md
Name: replacement_policy_pipe

Overview:
Next-generation cache victim selector. It keeps per-line replacement state in internal registers, for all three policies (LRU, PLRU_mru, PLRU_tree). It adds:
- a self-clearing init/flush sequencer;
- a registered lookup/response pipeline with same-cycle update bypass;
- invalid-way priority;
- per-request way locking.

It sits between the cache tag/valid stage and the way-select/write path in iob-cache.

Parameters:
- N_WAYS, 8: associativity; power of 2, >=2.
- NWAY_W, $clog2(N_WAYS): way index width.
- LINE_OFFSET_W, 7: line index width; N_LINES = 2**LINE_OFFSET_W.
- REP_POLICY, `PLRU_tree: `LRU (0), `PLRU_mru (1) or `PLRU_tree (3).

Ports:
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-low reset.
- flush, in, 1: re-clear all replacement state.
- busy, out, 1: init/flush in progress; requests are not accepted.
- req_valid, in, 1: victim lookup request.
- req_addr, in, LINE_OFFSET_W: line index of the lookup.
- req_way_valid, in, N_WAYS: valid bits of the addressed set.
- req_lock_mask, in, N_WAYS: 1 = way must not be chosen.
- resp_valid, out, 1: victim output valid, one-cycle pulse.
- way_select, out, N_WAYS: one-hot victim.
- way_select_bin, out, NWAY_W: binary victim.
- upd_valid, in, 1: access update request.
- upd_addr, in, LINE_OFFSET_W: line index to update.
- upd_way_hit, in, N_WAYS: one-hot accessed way; all-zero = no-op.

Behaviour:
- Reset (reset==0 at posedge):
  - FSM = INIT, init_cnt=0, busy=1.
  - resp_valid=0, way_select=0, way_select_bin=0.
  - State registers are not touched by reset itself.
- FSM INIT:
  - Each cycle, write the policy reset value to line init_cnt, then init_cnt++.
  - After the write of line N_LINES-1, go to READY next cycle; busy=0 from that cycle.
  - INIT therefore lasts exactly N_LINES cycles.
  - req_valid and upd_valid are ignored in INIT.
  - Re-asserting reset mid-INIT restarts at init_cnt=0.
- FSM READY:
  - flush=1 goes to INIT (init_cnt=0) next cycle, with busy=1 from that cycle.
  - A lookup or update in the flush cycle is still served.
  - A flush asserted during INIT is ignored.
- Policy reset values:
  - LRU: counter of way i = i, so way 0 is LRU.
  - mru: all bits 0.
  - tree: all N_WAYS-1 node bits 0, so way 0 is selected.
- Update (upd_valid & ~busy & |upd_way_hit), written at the posedge:
  - LRU: hit way counter = N_WAYS-1; counters greater than the hit way's old counter decrement; others are unchanged.
  - mru: next = mru|hit; if next is all-ones, next = hit.
  - tree: every node on the hit way's path is set to point away from the hit.
  - Multi-hot upd_way_hit is illegal (assertion).
- Lookup (req_valid & ~busy) at cycle t:
  - Response registered at t+1: resp_valid=1 for one cycle; way_select and way_select_bin hold until the next response.
  - Bypass: if upd_valid at t has upd_addr==req_addr, the victim is computed from the post-update state.
  - Back-to-back lookups are allowed every cycle.
- Victim selection, in priority order:
  - cand = ~req_lock_mask; if cand==0, cand = all ones.
  - Any candidate with req_way_valid==0: pick the lowest-index such way.
  - Otherwise, by policy:
    - LRU: the candidate with the lowest counter.
    - mru: the lowest-index candidate with mru bit 0; if none, the lowest-index candidate.
    - tree: the tree-traversal way if it is a candidate; else the lowest-index candidate.
- way_select is always one-hot on resp_valid, and way_select_bin matches it.

Decomposition:
- Policy encodings `LRU/`PLRU_mru/`PLRU_tree and the state width function (LRU: N_WAYS*NWAY_W; mru: N_WAYS; tree: N_WAYS-1) live in iob-cache.vh.
- Sub-module replacement_policy_logic (combinational) takes state, hit, valid and lock, and produces next_state, the victim and the reset value.
- The top level holds the FSM, init counter, state register array, bypass mux and output registers.

Test Plan:
1. Reset low 1 cycle, N_WAYS=4, LINE_OFFSET_W=2 -> busy=1 for exactly 4 cycles; then lookup addr 0, all valid, no lock -> way_select=4'b0001 one cycle later, each policy.
2. LRU, addr 1, updates hit ways 0,1,2,3 in order, all valid -> lookup returns way 0 (bin 0); one more hit on way 0 -> returns way 1.
3. Tree, addr 2, hit way 0 -> victim way 2 (4'b0100); same-cycle update hit way 2 plus lookup addr 2 -> victim way 1 (bypass).
4. req_way_valid=4'b1011 -> way 2 regardless of state; lock_mask=4'b0100 with the same valid -> way 0; lock_mask=4'b1111 -> way 2.
5. mru, hits ways 0,1,2 on addr 3 -> victim way 3; hit way 3 -> state resets to 4'b1000, victim way 0.
6. Flush in READY -> busy high 4 cycles, lookups ignored (resp_valid=0); afterwards all lines return way 0; reset low mid-flush restarts the 4-cycle count.
